// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle control unit: FSM states, opcode
// encodings and ALU operation codes.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALU_OP_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [OPCODE_W-1:0] OP_J      = 6'b110000;
  localparam logic [OPCODE_W-1:0] OP_JZ     = 6'b110001;
  localparam logic [OPCODE_W-1:0] OP_JNZ    = 6'b110010;
  localparam logic [OPCODE_W-1:0] OP_HALT   = 6'b111111;
  localparam logic [3:0]          LI_PREFIX = 4'b1000;

  localparam logic [ALU_OP_W-1:0] ALU_OP_0    = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_OP_1    = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_DEFAULT = 3'b111;

endpackage

// File: rtl/uc_multiciclo_if.sv
// Control bus between the multicycle control unit (master) and the
// datapath / program memory side (slave).
interface uc_multiciclo_if
  import cpu_pkg::*;
#(
  parameter int unsigned RET_W = 16
);

  logic                start;
  logic                mem_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                z;
  logic                s_inc;
  logic                s_inm;
  logic                we3;
  logic                wez;
  logic [ALU_OP_W-1:0] op_alu;
  logic                pc_we;
  logic                busy;
  logic                halted;
  logic                illegal;
  logic [RET_W-1:0]    retired;

  modport master (
    input  start, mem_ready, opcode, z,
    output s_inc, s_inm, we3, wez, op_alu, pc_we, busy, halted, illegal, retired
  );

  modport slave (
    output start, mem_ready, opcode, z,
    input  s_inc, s_inm, we3, wez, op_alu, pc_we, busy, halted, illegal, retired
  );

endinterface

// File: rtl/uc_decode.sv
// Combinational instruction decode of the latched opcode into datapath controls.
module uc_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] op_q,
  input  logic                z,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic [ALU_OP_W-1:0] op_alu,
  output logic                is_halt,
  output logic                is_illegal
);

  always_comb begin
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    op_alu     = ALU_DEFAULT;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (!op_q[5]) begin
      op_alu = op_q[4:2];
      we3    = 1'b1;
      wez    = 1'b1;
    end else if (op_q[5:2] == LI_PREFIX) begin
      we3   = 1'b1;
      s_inm = 1'b1;
    end else begin
      // z is the flag registered before this instruction, never its own wez
      case (op_q)
        OP_J:    s_inc = 1'b0;
        OP_JZ:   s_inc = ~z;
        OP_JNZ:  s_inc = z;
        OP_HALT: is_halt = 1'b1;
        default: is_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: sequences FETCH/EXEC for the single-cycle datapath,
// gates write enables to the EXEC cycle and counts retired instructions.
module uc_multiciclo
  import cpu_pkg::*;
#(
  parameter int unsigned RET_W = 16
)(
  input logic              clk,
  input logic              reset,
  uc_multiciclo_if.master  bus
);

  state_t              state;
  logic [OPCODE_W-1:0] op_q;
  logic [RET_W-1:0]    retired_q;
  logic                illegal_q;

  logic                exec;
  logic                dec_s_inc;
  logic                dec_s_inm;
  logic                dec_we3;
  logic                dec_wez;
  logic [ALU_OP_W-1:0] dec_op_alu;
  logic                is_halt;
  logic                is_illegal;

  uc_decode u_decode (
    .op_q       (op_q),
    .z          (bus.z),
    .s_inc      (dec_s_inc),
    .s_inm      (dec_s_inm),
    .we3        (dec_we3),
    .wez        (dec_wez),
    .op_alu     (dec_op_alu),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  // Enables depend only on registered state and op_q, never on live opcode
  assign exec        = (state == EXEC);
  assign bus.s_inc   = exec ? dec_s_inc : 1'b1;
  assign bus.s_inm   = dec_s_inm;
  assign bus.op_alu  = dec_op_alu;
  assign bus.we3     = exec & dec_we3;
  assign bus.wez     = exec & dec_wez;
  assign bus.pc_we   = exec & ~is_halt;
  assign bus.busy    = (state == FETCH) || (state == EXEC);
  assign bus.halted  = (state == HALT);
  assign bus.illegal = illegal_q;
  assign bus.retired = retired_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      op_q      <= OP_HALT;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) state <= FETCH;
        end
        FETCH: begin
          if (bus.mem_ready) begin
            op_q  <= bus.opcode;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (is_halt) begin
            state <= HALT;
          end else begin
            retired_q <= retired_q + RET_W'(1);
            illegal_q <= illegal_q | is_illegal;
            state     <= FETCH;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
